// File: rtl/array_access_arbiter_pkg.sv
// Shared definitions for the array access arbiter and the array_dataflow family:
// op encoding, FSM state codes and the address-width helper.
package array_access_arbiter_pkg;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   localparam logic [1:0] ST_RST  = 2'd0;
   localparam logic [1:0] ST_INIT = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   // Address width for a given depth; never below one bit.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to prio,
// and prio moves to the other requester after every grant.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       enable,
   output logic [1:0] grant
);

   logic r_prio;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant = 2'b00;
      if (enable) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prio <= 1'b0;
      end else if (grant[0]) begin
         r_prio <= 1'b1;
      end else if (grant[1]) begin
         r_prio <= 1'b0;
      end
   end

endmodule

// File: rtl/array_access_arbiter.sv
// Sole owner of the array_dataflow memory ports: clears the memory after reset,
// then serves one request per cycle from two round-robin requesters.
module array_access_arbiter
   import array_access_arbiter_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int ADDR  = clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [1:0]           req_we,
   input  logic [2*ADDR-1:0]    req_addr,
   input  logic [2*WIDTH-1:0]   req_wdata,
   output logic [1:0]           rsp_valid,
   output logic [2*WIDTH-1:0]   rsp_rdata,
   output logic                 busy,
   output logic                 mem_write_en,
   output logic [ADDR-1:0]      mem_write_addr,
   output logic [WIDTH-1:0]     mem_write_data,
   output logic [ADDR-1:0]      mem_read_addr,
   input  logic [WIDTH-1:0]     mem_read_data
);

   localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);
   localparam logic [ADDR:0]   DEPTH_W   = (ADDR + 1)'(DEPTH);

   logic [1:0]         r_state;
   logic [ADDR-1:0]    r_clr_cnt;
   logic [1:0]         r_rsp_valid;
   logic [2*WIDTH-1:0] r_rsp_rdata;

   logic [1:0]       w_grant;
   logic             w_run;
   logic             w_any;
   logic             w_sel;
   logic [ADDR-1:0]  w_addr;
   logic             w_we;
   logic [WIDTH-1:0] w_wdata;
   logic             w_in_range;
   logic             w_read_grant;
   logic [WIDTH-1:0] w_rd_data;

   assign w_run = (r_state == ST_RUN);

   rr_arbiter2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req_valid),
      .enable (w_run),
      .grant  (w_grant)
   );

   // The grant is one-hot, so bit 1 alone selects the winning requester.
   assign w_any        = |w_grant;
   assign w_sel        = w_grant[1];
   assign w_addr       = w_sel ? req_addr[2*ADDR-1:ADDR]    : req_addr[ADDR-1:0];
   assign w_wdata      = w_sel ? req_wdata[2*WIDTH-1:WIDTH] : req_wdata[WIDTH-1:0];
   assign w_we         = w_sel ? req_we[1] : req_we[0];
   assign w_in_range   = ({1'b0, w_addr} < DEPTH_W);
   assign w_read_grant = w_any && (w_we == OP_READ);
   assign w_rd_data    = w_in_range ? mem_read_data : '0;

   assign req_ready = w_grant;
   assign busy      = !w_run;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_RST;
         r_clr_cnt <= '0;
      end else begin
         case (r_state)
            ST_RST: begin
               r_state   <= ST_INIT;
               r_clr_cnt <= '0;
            end
            ST_INIT: begin
               r_clr_cnt <= r_clr_cnt + ADDR'(1);
               if (r_clr_cnt == LAST_ADDR) r_state <= ST_RUN;
            end
            ST_RUN:  r_state <= ST_RUN;
            default: r_state <= ST_RST;
         endcase
      end
   end

   always_comb begin
      mem_write_en   = 1'b0;
      mem_write_addr = '0;
      mem_write_data = '0;
      mem_read_addr  = '0;
      if (r_state == ST_INIT) begin
         mem_write_en   = 1'b1;
         mem_write_addr = r_clr_cnt;
      end else if (w_any && w_in_range) begin
         // Out-of-range requests still handshake but never touch the memory.
         if (w_we == OP_WRITE) begin
            mem_write_en   = 1'b1;
            mem_write_addr = w_addr;
            mem_write_data = w_wdata;
         end else begin
            mem_read_addr = w_addr;
         end
      end
   end

   // NOTE: only control and response registers are reset; the memory array itself is cleared by the INIT sweep, not by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 2'b00;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= w_read_grant ? w_grant : 2'b00;
         if (w_read_grant && w_grant[0]) r_rsp_rdata[WIDTH-1:0]       <= w_rd_data;
         if (w_read_grant && w_grant[1]) r_rsp_rdata[2*WIDTH-1:WIDTH] <= w_rd_data;
      end
   end

endmodule

// File: tb/tb_array_access_arbiter.sv
// Bench for array_access_arbiter: a DEPTH=4 and a DEPTH=3 instance share stimulus
// and are both checked every cycle against a behavioural model.
module tb_array_access_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_we;
   logic [3:0]  req_addr;
   logic [15:0] req_wdata;

   logic [1:0]  ready     [2];
   logic [1:0]  rsp_valid [2];
   logic [15:0] rsp_rdata [2];
   logic        busy      [2];
   logic        wen       [2];
   logic [1:0]  waddr     [2];
   logic [7:0]  wdata     [2];
   logic [1:0]  raddr     [2];
   logic [7:0]  rdata     [2];

   logic [7:0]  bmem [2][4];

   int total = 0;
   int bad   = 0;

   int         dep    [2] = '{4, 3};
   int         cnt    [2];
   int         prio_m [2];
   logic [7:0] ref_mem[2][4];
   logic [1:0] exp_rv [2];
   logic [15:0] exp_rd[2];

   array_access_arbiter #(.WIDTH(8), .DEPTH(4)) u_d4 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready[0]),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
      .mem_write_en(wen[0]), .mem_write_addr(waddr[0]), .mem_write_data(wdata[0]),
      .mem_read_addr(raddr[0]), .mem_read_data(rdata[0])
   );

   array_access_arbiter #(.WIDTH(8), .DEPTH(3)) u_d3 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready[1]),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
      .mem_write_en(wen[1]), .mem_write_addr(waddr[1]), .mem_write_data(wdata[1]),
      .mem_read_addr(raddr[1]), .mem_read_data(rdata[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural memories standing in for array_dataflow; the 3-word one returns garbage out of range.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) if (wen[i]) bmem[i][waddr[i]] <= wdata[i];
   end
   assign rdata[0] = bmem[0][raddr[0]];
   assign rdata[1] = (raddr[1] < 2'd3) ? bmem[1][raddr[1]] : 8'hEE;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // cnt = rising edges seen since reset release (saturating at d+1): 0 is RST, 1..d clear, d+1 serving.
   task automatic model_step(input int i);
      int d, k, a;
      logic we;
      logic [7:0] wd, rd;
      logic [1:0] e_ready, e_waddr, e_raddr;
      logic [7:0] e_wdata;
      logic e_wen, chk_raddr;
      string p;
      d = dep[i];
      p = $sformatf("d%0d", d);
      k = 0; a = 0; we = 1'b0; wd = 8'h00;
      if (!rst_n) begin
         cnt[i] = 0; prio_m[i] = 0; exp_rv[i] = 2'b00; exp_rd[i] = 16'h0000;
      end
      e_ready = 2'b00; e_wen = 1'b0; e_waddr = 2'b00; e_wdata = 8'h00;
      e_raddr = 2'b00; chk_raddr = 1'b1;
      if (cnt[i] >= 1 && cnt[i] <= d) begin
         e_wen = 1'b1;
         e_waddr = 2'(cnt[i] - 1);
      end else if (cnt[i] > d && req_valid != 2'b00) begin
         k = (req_valid == 2'b11) ? prio_m[i] : (req_valid[1] ? 1 : 0);
         e_ready = 2'(1 << k);
         a = int'(req_addr[k*2 +: 2]);
         we = req_we[k];
         wd = req_wdata[k*8 +: 8];
         if (we) begin
            if (a < d) begin e_wen = 1'b1; e_waddr = 2'(a); e_wdata = wd; end
         end else if (a < d) begin
            e_raddr = 2'(a);
         end else begin
            chk_raddr = 1'b0;
         end
      end
      check({p, "_busy"},      32'(busy[i]),      32'(cnt[i] <= d));
      check({p, "_ready"},     32'(ready[i]),     32'(e_ready));
      check({p, "_wen"},       32'(wen[i]),       32'(e_wen));
      check({p, "_waddr"},     32'(waddr[i]),     32'(e_waddr));
      check({p, "_wdata"},     32'(wdata[i]),     32'(e_wdata));
      if (chk_raddr) check({p, "_raddr"}, 32'(raddr[i]), 32'(e_raddr));
      check({p, "_rsp_valid"}, 32'(rsp_valid[i]), 32'(exp_rv[i]));
      check({p, "_rsp_rdata"}, 32'(rsp_rdata[i]), 32'(exp_rd[i]));
      if (rst_n) begin
         exp_rv[i] = 2'b00;
         if (e_ready != 2'b00) begin
            if (!we) begin
               rd = (a < d) ? ref_mem[i][a] : 8'h00;
               exp_rv[i] = e_ready;
               if (k == 1) exp_rd[i][15:8] = rd;
               else        exp_rd[i][7:0]  = rd;
            end else if (a < d) begin
               ref_mem[i][a] = wd;
            end
            prio_m[i] = 1 - k;
         end
         if (cnt[i] >= 1 && cnt[i] <= d) ref_mem[i][cnt[i] - 1] = 8'h00;
         if (cnt[i] <= d) cnt[i]++;
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) model_step(i);
   end

   task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [3:0] a,
                        input logic [15:0] wd);
      @(posedge clk);
      #1;
      req_valid = v; req_we = we; req_addr = a; req_wdata = wd;
      @(negedge clk);
   endtask

   task automatic wait_run();
      int n;
      n = 0;
      while ((busy[0] || busy[1]) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("wait_run_busy", 32'(busy[0] | busy[1]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int nb4, nb3, nw4, ng, np;
      logic [7:0] seq4;
      rst_n = 1'b0;
      req_valid = 2'b00; req_we = 2'b00; req_addr = 4'h0; req_wdata = 16'h0000;
      repeat (3) @(posedge clk);

      // Reset clear sweep.
      #1 rst_n = 1'b1;
      nb4 = 0; nb3 = 0; nw4 = 0; seq4 = 8'h00;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (busy[0]) nb4++;
         if (busy[1]) nb3++;
         if (wen[0] && nw4 < 4) begin
            seq4 = seq4 | (8'(waddr[0]) << (2 * nw4));
            nw4++;
         end
      end
      check("busy_edges_d4", 32'(nb4), 32'd5);
      check("busy_edges_d3", 32'(nb3), 32'd4);
      check("clear_writes_d4", 32'(nw4), 32'd4);
      check("clear_addr_seq_d4", 32'(seq4), 32'hE4);
      for (int a = 0; a < 4; a++) begin
         drive(2'b01, 2'b00, 4'(a), 16'h0000);
         drive(2'b00, 2'b00, 4'h0, 16'h0000);
         check("clear_read_d4", 32'(rsp_rdata[0][7:0]), 32'h00);
      end

      // Cross-requester read-after-write.
      drive(2'b01, 2'b01, 4'b0010, 16'h005A);
      check("xreq_wr_ready", 32'(ready[0]), 32'h1);
      drive(2'b10, 2'b00, 4'b1000, 16'h0000);
      check("xreq_rd_ready", 32'(ready[0]), 32'h2);
      check("xreq_no_early_rsp", 32'(rsp_valid[0]), 32'h0);
      drive(2'b00, 2'b00, 4'h0, 16'h0000);
      check("xreq_rsp_valid", 32'(rsp_valid[0]), 32'h2);
      check("xreq_rsp_data", 32'(rsp_rdata[0][15:8]), 32'h5A);
      drive(2'b00, 2'b00, 4'h0, 16'h0000);
      check("xreq_rsp_gone", 32'(rsp_valid[0]), 32'h0);

      // Contention: both write every cycle.
      for (int c = 0; c < 6; c++) begin
         drive(2'b11, 2'b11, 4'b1101, {8'(c + 8'h10), 8'(c)});
         check("contention_grant", 32'(ready[0]), (c % 2 == 0) ? 32'h1 : 32'h2);
      end

      // Single requester back-to-back reads.
      ng = 0; np = 0;
      for (int c = 0; c < 3; c++) begin
         drive(2'b10, 2'b00, 4'b1100, 16'h0000);
         if (ready[0] == 2'b10) ng++;
         if (rsp_valid[0][1]) np++;
      end
      drive(2'b00, 2'b00, 4'h0, 16'h0000);
      if (rsp_valid[0][1]) np++;
      check("single_grants", 32'(ng), 32'd3);
      check("single_pulses", 32'(np), 32'd3);
      check("single_rdata", 32'(rsp_rdata[0][15:8]), 32'h15);

      // Reset while a read response is in flight.
      drive(2'b01, 2'b01, 4'b0001, 16'h00FF);
      drive(2'b01, 2'b00, 4'b0001, 16'h0000);
      check("rstmid_read_ready", 32'(ready[0]), 32'h1);
      #2 rst_n = 1'b0;
      drive(2'b00, 2'b00, 4'h0, 16'h0000);
      check("rstmid_no_rsp", 32'(rsp_valid[0]), 32'h0);
      check("rstmid_rdata_cleared", 32'(rsp_rdata[0]), 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_run();
      drive(2'b01, 2'b00, 4'b0001, 16'h0000);
      drive(2'b00, 2'b00, 4'h0, 16'h0000);
      check("rstmid_reread_valid", 32'(rsp_valid[0]), 32'h1);
      check("rstmid_reread_data", 32'(rsp_rdata[0][7:0]), 32'h00);

      // Out-of-range on the 3-word instance (address 3 is legal for the 4-word one).
      drive(2'b01, 2'b01, 4'b0011, 16'h0077);
      check("oor_wr_ready_d3", 32'(ready[1]), 32'h1);
      check("oor_wr_wen_d3", 32'(wen[1]), 32'h0);
      drive(2'b01, 2'b00, 4'b0011, 16'h0000);
      drive(2'b00, 2'b00, 4'h0, 16'h0000);
      check("oor_rd_valid_d3", 32'(rsp_valid[1]), 32'h1);
      check("oor_rd_data_d3", 32'(rsp_rdata[1][7:0]), 32'h00);
      check("inrange_rd_data_d4", 32'(rsp_rdata[0][7:0]), 32'h77);

      // Randomized traffic with one reset in the middle.
      for (int c = 0; c < 400; c++) begin
         @(posedge clk);
         #1;
         if (c == 200) rst_n = 1'b0;
         if (c == 202) rst_n = 1'b1;
         req_valid = 2'($urandom_range(0, 3));
         req_we    = 2'($urandom_range(0, 3));
         req_addr  = 4'($urandom_range(0, 15));
         req_wdata = 16'($urandom);
      end
      drive(2'b00, 2'b00, 4'h0, 16'h0000);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/array_access_arbiter.md
# array_access_arbiter

Two-requester access controller that owns the single write port and single combinational read port of the `array_dataflow` memory. It clears the memory after reset, then grants one transaction per cycle using round-robin arbitration. Read data is returned through a registered response channel. It sits between the memory and its two client blocks, and is the only block allowed to drive the memory ports.

## Interface
- `WIDTH`, 8, data word width in bits
- `DEPTH`, 4, number of memory words; need not be a power of two
- `ADDR`, clog2(DEPTH), address width; derived, never overridden
- `clk`  in  1  clock; memory writes and all state update on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  2  per-requester request valid; bit k belongs to requester k
- `req_ready`  out  2  per-requester grant; handshake occurs when valid and ready are both 1
- `req_we`  in  2  per-requester op: 1 = write, 0 = read
- `req_addr`  in  2*ADDR  requester k address at `[k*ADDR +: ADDR]`
- `req_wdata`  in  2*WIDTH  requester k write data at `[k*WIDTH +: WIDTH]`
- `rsp_valid`  out  2  one-cycle pulse on bit k carrying read data for requester k
- `rsp_rdata`  out  2*WIDTH  read data; field k is valid only when `rsp_valid[k]` is 1
- `busy`  out  1  high while reset or memory clear is in progress
- `mem_write_en`, `mem_write_addr` (ADDR), `mem_write_data` (WIDTH)  out  memory write port
- `mem_read_addr`  out  ADDR  memory read address
- `mem_read_data`  in  WIDTH  combinational memory read data

## Operation
- **FSM states: RST, INIT, RUN.** Asynchronous reset forces RST.
- **RST:** all memory controls are 0. At the first rising edge with `rst_n` high, the FSM moves to INIT and the clear counter is set to 0.
- **INIT:** each cycle drives `mem_write_en`=1, `mem_write_addr`=counter, `mem_write_data`=0, then increments the counter. The transition to RUN happens on the edge that writes address DEPTH-1. `req_ready` is 00 throughout.
- **RUN:** at most one grant per cycle.
  - A priority pointer `prio` (reset 0) selects the winner when both requesters are valid.
  - A single valid requester wins immediately, whatever `prio` is.
  - After a grant to requester k, `prio` becomes 1-k. With no grant, `prio` holds.
  - `req_ready` is combinational from `req_valid`, state and `prio`, and is one-hot or zero.
- **Granted write:** `mem_write_en`, `mem_write_addr` and `mem_write_data` come combinationally from the winner. The memory updates at the end of the grant cycle.
- **Granted read:** `mem_read_addr` is driven by the winner's address. `mem_read_data` is captured into `rsp_rdata[k]` at the end of the grant cycle, and `rsp_valid[k]` pulses in the next cycle.
- **Out of range** (`addr >= DEPTH`): the handshake still completes. A write is dropped (`mem_write_en` stays 0). A read returns 0 with `rsp_valid`.
- **Idle defaults:** `mem_read_addr` = 0; `mem_write_*` = 0.

## Timing
- **Reset values:** `req_ready`=00, `rsp_valid`=00, `rsp_rdata`=0, `busy`=1, `mem_write_en`=0, `prio`=0.
- **Busy window:** `busy` falls after DEPTH+1 rising edges following `rst_n` release. RUN therefore begins in cycle DEPTH+2.
- **Latency:** write is visible to reads in the next cycle. Read latency is 1 cycle from handshake to `rsp_valid`.
- **Read-after-write:** a write in cycle N followed by a read of the same address in cycle N+1 returns the new data.
- **Simultaneous write and read requests:** only one is served per cycle. Round-robin bounds the wait to 1 cycle.
- **Throughput:** back-to-back handshakes from a single requester are allowed, one per cycle.
- **No queueing:** there is no response backpressure. `rsp_rdata[k]` holds its last value until the next read by k.
- **Reset mid-operation:** an in-flight read response is discarded (`rsp_valid` is cleared immediately), the FSM re-enters RST, and the memory is fully cleared again.

## Structure
- **Shared include file:** the `clog2` function and the op encoding constants `OP_READ`=0 and `OP_WRITE`=1. These are reused by `array_dataflow` and its benches.
- **Sub-module `rr_arbiter2`:** holds the `prio` register.
  - Inputs: `clk`, `rst_n`, `req`[1:0], `enable`.
  - Output: one-hot `grant`[1:0].
- **Top level:** owns the FSM, the clear counter, the range check, the port muxing and the response registers.

## Test plan
1. **Reset clear** (DEPTH=4, WIDTH=8): release `rst_n` -> `busy` high for 5 edges; `mem_write_en` high for exactly 4 cycles at addresses 0,1,2,3 with data 00; reads of all addresses then return 00.
2. **Cross-requester read:** requester 0 writes 0x5A to address 2; the next cycle requester 1 reads address 2 -> `rsp_valid`=10 one cycle later, field 1 = 0x5A; `rsp_valid[0]` never asserts.
3. **Contention:** both requesters held valid with writes for 6 cycles -> grants alternate 0,1,0,1,0,1; `req_ready` is never 11.
4. **Single requester:** only requester 1 valid, reading address 3 for 3 consecutive cycles -> granted every cycle; 3 `rsp_valid[1]` pulses.
5. **Reset mid-stream:** write 0xFF to address 1, issue a read, assert `rst_n` low in the cycle before `rsp_valid` -> no `rsp_valid` pulse; after re-clear, address 1 reads 00.
6. **Out of range** (DEPTH=3): write 0x77 to address 3 -> handshake completes, `mem_write_en`=0; read of address 3 -> `rsp_valid` with 00.
